// File: rtl/acc_mq_pkg.sv
// Shared types and constants for the Acc/MQ/DR command sequencer.
package acc_mq_pkg;

  localparam int W = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    IDLE, LD_DR, LD_MQ, CLR_ACC, EXEC, RD_ACC, RD_MQ, DONE
  } state_e;

  localparam logic [2:0] DP_INS_NOP = 3'b000;
  localparam logic [2:0] DP_INS_ADD = 3'b000;
  localparam logic [2:0] DP_INS_SUB = 3'b001;
  localparam logic [2:0] DP_INS_AND = 3'b010;
  localparam logic [2:0] DP_INS_OR  = 3'b011;
  localparam logic [2:0] DP_INS_XOR = 3'b100;
  localparam logic [2:0] DP_INS_MUL = 3'b101;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic [2:0] dp_ins_of(input op_e op);
    case (op)
      OP_ADD:  return DP_INS_ADD;
      OP_SUB:  return DP_INS_SUB;
      OP_AND:  return DP_INS_AND;
      OP_OR:   return DP_INS_OR;
      OP_XOR:  return DP_INS_XOR;
      OP_MUL:  return DP_INS_MUL;
      default: return DP_INS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/acc_mq_step_ctr.sv
// EXEC step counter: 3-bit, cleared outside EXEC; tc flags the last MUL step.
// Latency: tc is combinational from the count; no backpressure.
module acc_mq_step_ctr
  import acc_mq_pkg::*;
#(
  parameter int MUL_STEPS = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [2:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cnt <= 3'd0;
    else if (clr) cnt <= 3'd0;
    else if (en)  cnt <= cnt + 3'd1;
  end

  assign tc = en && (cnt == 3'(MUL_STEPS - 1));

endmodule

// File: rtl/acc_mq_sequencer.sv
// Sequences one Acc/MQ/DR request into load/exec/read-back strobes; responds 7 cycles
// after accept (MUL: 6+MUL_STEPS, illegal: 1); holds the response until rsp_ready.
module acc_mq_sequencer
  import acc_mq_pkg::*;
#(
  parameter int MUL_STEPS = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_hi,
  output logic [W-1:0] rsp_lo,
  output logic         rsp_err,
  output logic [W-1:0] dp_bus_out,
  input  logic [W-1:0] dp_bus_in,
  output logic         dp_ld_dr,
  output logic         dp_ld_mq,
  output logic         dp_ld_acc,
  output logic         dp_st_acc,
  output logic         dp_st_mq,
  output logic [2:0]   dp_ins,
  output logic         dp_step,
  output logic         busy
);

  state_e       state, state_nxt;
  op_e          op_q;
  logic [W-1:0] b_q;
  logic         step_tc;
  logic         nxt_ld_dr, nxt_ld_mq, nxt_ld_acc, nxt_st_acc, nxt_st_mq, nxt_step;
  logic [W-1:0] nxt_bus;
  logic [2:0]   nxt_ins;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

  acc_mq_step_ctr #(.MUL_STEPS(MUL_STEPS)) u_step_ctr (
    .clock (clock),
    .reset (reset),
    .clr   (state != EXEC),
    .en    (state == EXEC),
    .tc    (step_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobes are registered, so they are decoded from the state being entered.
  // DR is loaded straight from req_a on the accept edge; the bus register holds it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = op_legal(req_op) ? LD_DR : DONE;
      LD_DR:   state_nxt = LD_MQ;
      LD_MQ:   state_nxt = CLR_ACC;
      CLR_ACC: state_nxt = EXEC;
      EXEC:    if (op_q != OP_MUL || step_tc) state_nxt = RD_ACC;
      RD_ACC:  state_nxt = RD_MQ;
      RD_MQ:   state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    nxt_ld_dr  = (state_nxt == LD_DR);
    nxt_ld_mq  = (state_nxt == LD_MQ);
    nxt_ld_acc = (state_nxt == CLR_ACC);
    nxt_step   = (state_nxt == EXEC);
    nxt_st_acc = (state_nxt == RD_ACC);
    nxt_st_mq  = (state_nxt == RD_MQ);
    nxt_ins    = nxt_step ? dp_ins_of(op_q) : DP_INS_NOP;
    nxt_bus    = '0;
    if (nxt_ld_dr)      nxt_bus = req_a;
    else if (nxt_ld_mq) nxt_bus = b_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dp_ld_dr   <= 1'b0;
      dp_ld_mq   <= 1'b0;
      dp_ld_acc  <= 1'b0;
      dp_st_acc  <= 1'b0;
      dp_st_mq   <= 1'b0;
      dp_step    <= 1'b0;
      dp_ins     <= DP_INS_NOP;
      dp_bus_out <= '0;
    end else begin
      dp_ld_dr   <= nxt_ld_dr;
      dp_ld_mq   <= nxt_ld_mq;
      dp_ld_acc  <= nxt_ld_acc;
      dp_st_acc  <= nxt_st_acc;
      dp_st_mq   <= nxt_st_mq;
      dp_step    <= nxt_step;
      dp_ins     <= nxt_ins;
      dp_bus_out <= nxt_bus;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      b_q     <= '0;
      rsp_hi  <= '0;
      rsp_lo  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        op_q    <= op_e'(req_op);
        b_q     <= req_b;
        rsp_hi  <= '0;
        rsp_lo  <= '0;
        rsp_err <= !op_legal(req_op);
      end
      if (state == RD_ACC) rsp_hi <= dp_bus_in;
      if (state == RD_MQ)  rsp_lo <= dp_bus_in;
      if (state == DONE && rsp_ready) rsp_err <= 1'b0;
    end
  end

endmodule
